// File: rtl/gate_stim_sequencer_pkg.sv
// Shared definitions for the All_Gates stimulus/capture sequencer: FSM state
// encoding, gate vector layout and error-counter limits.
package gate_stim_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   localparam int GATE_VEC_W = 7;
   localparam int SAMPLE_W   = GATE_VEC_W + 2;

   // Bit position of each gate output inside gates_in
   localparam int GATE_AND  = 6;
   localparam int GATE_OR   = 5;
   localparam int GATE_NOT  = 4;
   localparam int GATE_NAND = 3;
   localparam int GATE_NOR  = 2;
   localparam int GATE_XOR  = 1;
   localparam int GATE_XNOR = 0;

   localparam int          ERR_W   = 3;
   localparam logic [2:0]  ERR_MAX = 3'd4;

endpackage

// File: rtl/gate_stim_sequencer_golden.sv
// Reference All_Gates response for a given (a,b); used by the optional
// self-check comparator in gate_stim_sequencer.
module gate_golden_model
   import gate_stim_sequencer_pkg::*;
(
   input  logic                  i_a,
   input  logic                  i_b,
   output logic [GATE_VEC_W-1:0] o_gates
);

   always_comb begin
      o_gates            = '0;
      o_gates[GATE_AND]  = i_a & i_b;
      o_gates[GATE_OR]   = i_a | i_b;
      o_gates[GATE_NOT]  = ~i_a;
      o_gates[GATE_NAND] = ~(i_a & i_b);
      o_gates[GATE_NOR]  = ~(i_a | i_b);
      o_gates[GATE_XOR]  = i_a ^ i_b;
      o_gates[GATE_XNOR] = ~(i_a ^ i_b);
   end

endmodule

// File: rtl/gate_stim_sequencer.sv
// Walks {a,b} through 00..11, dwells, captures All_Gates outputs per vector.
// Optional GATE_CHECK_EN adds a golden comparator driving err_cnt.
module gate_stim_sequencer
   import gate_stim_sequencer_pkg::*;
#(
   parameter int DWELL_CYCLES = 10,
   parameter int CNT_W        = $clog2(DWELL_CYCLES + 1)
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [GATE_VEC_W-1:0] gates_in,
   output logic                  a,
   output logic                  b,
   output logic                  busy,
   output logic [1:0]            vec_idx,
   output logic                  sample_valid,
   output logic [SAMPLE_W-1:0]   sample_data,
   output logic                  done,
   output logic [ERR_W-1:0]      err_cnt
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [1:0]            r_vec_idx;
   logic                  r_sample_valid;
   logic [SAMPLE_W-1:0]   r_sample_data;
   logic                  w_drive;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_a;
   logic                  w_b;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_state_nxt = ST_APPLY;
         ST_APPLY:  if (r_cnt == DWELL_LAST) w_state_nxt = ST_SAMPLE;
         ST_SAMPLE: w_state_nxt = (r_vec_idx == 2'd3) ? ST_FINISH : ST_APPLY;
         ST_FINISH: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Stimulus is only driven while a vector is live; FINISH returns a,b to 0
   always_comb begin
      w_drive = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         ST_APPLY:  begin w_drive = 1'b1; w_busy = 1'b1; end
         ST_SAMPLE: begin w_drive = 1'b1; w_busy = 1'b1; end
         ST_FINISH: w_done = 1'b1;
         default:   ;
      endcase
   end

   assign w_a = w_drive & r_vec_idx[1];
   assign w_b = w_drive & r_vec_idx[0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt          <= '0;
         r_vec_idx      <= 2'd0;
         r_sample_valid <= 1'b0;
         r_sample_data  <= '0;
      end else begin
         r_sample_valid <= (r_state == ST_SAMPLE);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_cnt     <= '0;
                  r_vec_idx <= 2'd0;
               end
            end
            ST_APPLY: r_cnt <= r_cnt + 1'b1;
            ST_SAMPLE: begin
               r_sample_data <= {w_a, w_b, gates_in};
               if (r_vec_idx != 2'd3) begin
                  r_vec_idx <= r_vec_idx + 2'd1;
                  r_cnt     <= '0;
               end
            end
            ST_FINISH: r_vec_idx <= 2'd0;
            default: ;
         endcase
      end
   end

`ifdef GATE_CHECK_EN
   logic [GATE_VEC_W-1:0] w_golden;
   logic                  w_mismatch;
   logic [ERR_W-1:0]      r_err_cnt;

   gate_golden_model u_golden (
      .i_a     (w_a),
      .i_b     (w_b),
      .o_gates (w_golden)
   );

   assign w_mismatch = (gates_in != w_golden);

   // Count survives done so software can read it until the next start
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
      end else if (r_state == ST_IDLE && start) begin
         r_err_cnt <= '0;
      end else if (r_state == ST_SAMPLE && w_mismatch && r_err_cnt != ERR_MAX) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = '0;
`endif

   assign a            = w_a;
   assign b            = w_b;
   assign busy         = w_busy;
   assign vec_idx      = r_vec_idx;
   assign sample_valid = r_sample_valid;
   assign sample_data  = r_sample_data;
   assign done         = w_done;

endmodule

// File: tb/tb_gate_stim_sequencer.sv
// Directed bench for gate_stim_sequencer: two instances (dwell 10 and dwell 1)
// driven by a behavioural All_Gates stand-in with an optional xor fault.
module tb_gate_stim_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0, start1;
   logic       sel;
   logic       xor_fault;

   logic [6:0] g0, g1;
   logic       a0, b0, busy0, sv0, done0;
   logic       a1, b1, busy1, sv1, done1;
   logic [1:0] vec0, vec1;
   logic [8:0] sd0, sd1;
   logic [2:0] err0, err1;

   logic       m_valid, m_done, m_busy;
   logic [8:0] m_data;
   logic [2:0] m_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [6:0] all_gates(input logic ia, input logic ib, input logic flt);
      logic [6:0] g;
      g = {ia & ib, ia | ib, ~ia, ~(ia & ib), ~(ia | ib), ia ^ ib, ~(ia ^ ib)};
      if (flt) g[1] = 1'b0;
      return g;
   endfunction

   assign g0 = all_gates(a0, b0, xor_fault);
   assign g1 = all_gates(a1, b1, 1'b0);

   gate_stim_sequencer #(.DWELL_CYCLES(10)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start0),
      .gates_in     (g0),
      .a            (a0),
      .b            (b0),
      .busy         (busy0),
      .vec_idx      (vec0),
      .sample_valid (sv0),
      .sample_data  (sd0),
      .done         (done0),
      .err_cnt      (err0)
   );

   gate_stim_sequencer #(.DWELL_CYCLES(1)) dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start1),
      .gates_in     (g1),
      .a            (a1),
      .b            (b1),
      .busy         (busy1),
      .vec_idx      (vec1),
      .sample_valid (sv1),
      .sample_data  (sd1),
      .done         (done1),
      .err_cnt      (err1)
   );

   assign m_valid = sel ? sv1   : sv0;
   assign m_done  = sel ? done1 : done0;
   assign m_busy  = sel ? busy1 : busy0;
   assign m_data  = sel ? sd1   : sd0;
   assign m_err   = sel ? err1  : err0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input logic v);
      if (sel) start1 = v;
      else     start0 = v;
   endtask

   // One full run on the selected instance; mid_c > 0 re-pulses start in that cycle
   task automatic run(input int d, input int mid_c, input bit chk_data, input logic [2:0] exp_err);
      logic [8:0] data [4];
      logic [8:0] exp_data [4];
      int         cyc [4];
      int         n, done_c, dbl;
      bit         prev_v;
      exp_data[0] = 9'h01D;
      exp_data[1] = 9'h0BA;
      exp_data[2] = 9'h12A;
      exp_data[3] = 9'h1E1;
      for (int i = 0; i < 4; i++) begin
         data[i] = 'x;
         cyc[i]  = 0;
      end
      n = 0; done_c = -1; dbl = 0; prev_v = 1'b0;
      set_start(1'b1);
      tick();
      set_start(1'b0);
      for (int c = 1; c <= 4 * (d + 1) + 20 && done_c < 0; c++) begin
         if (m_valid) begin
            if (prev_v) dbl++;
            if (n < 4) begin
               data[n] = m_data;
               cyc[n]  = c;
            end
            n++;
         end
         prev_v = m_valid;
         if (m_done) begin
            done_c = c;
            check_eq("busy_at_done", {31'd0, m_busy}, 32'd0);
         end else begin
            set_start(c == mid_c);
            tick();
         end
      end
      set_start(1'b0);
      check_eq("sample_count", n, 4);
      check_eq("done_cycle", done_c, 4 * (d + 1) + 1);
      check_eq("valid_back_to_back", dbl, 0);
      check_eq("first_sample_cycle", cyc[0], d + 2);
      for (int i = 1; i < 4; i++)
         check_eq($sformatf("sample_spacing%0d", i), cyc[i] - cyc[i-1], d + 1);
      if (chk_data)
         for (int i = 0; i < 4; i++)
            check_eq($sformatf("sample_data%0d", i), {23'd0, data[i]}, {23'd0, exp_data[i]});
      check_eq("err_cnt", {29'd0, m_err}, {29'd0, exp_err});
      tick();
      check_eq("done_width", {31'd0, m_done}, 32'd0);
      check_eq("idle_busy", {31'd0, m_busy}, 32'd0);
   endtask

   initial begin
      int dseen;
      rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; sel = 1'b0; xor_fault = 1'b0;
      repeat (3) tick();
      check_eq("reset_outs0", {a0, b0, busy0, vec0, sv0, done0, sd0, err0}, 32'd0);
      check_eq("reset_outs1", {a1, b1, busy1, vec1, sv1, done1, sd1, err1}, 32'd0);
      rst_n = 1'b1;
      tick();
      check_eq("post_reset_outs0", {a0, b0, busy0, vec0, sv0, done0, sd0, err0}, 32'd0);

      // Start coincident with reset must be dropped
      rst_n = 1'b0; start0 = 1'b1;
      tick();
      rst_n = 1'b1; start0 = 1'b0;
      check_eq("start_with_reset_busy", {31'd0, busy0}, 32'd0);
      tick();
      check_eq("start_with_reset_idle", {31'd0, busy0}, 32'd0);

      sel = 1'b0;
      run(10, 0, 1'b1, 3'd0);
      run(10, 16, 1'b1, 3'd0);

      sel = 1'b1;
      run(1, 0, 1'b1, 3'd0);
      sel = 1'b0;

      // Abort during SAMPLE of vector 2 (cycle 33 with dwell 10)
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (32) tick();
      check_eq("abort_pre_busy", {31'd0, busy0}, 32'd1);
      check_eq("abort_pre_vec", {30'd0, vec0}, 32'd2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("abort_outs", {a0, b0, busy0, vec0, sv0, done0, sd0, err0}, 32'd0);
      dseen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done0 || sv0 || busy0) dseen++;
      end
      check_eq("abort_quiet", dseen, 0);
      run(10, 0, 1'b1, 3'd0);

`ifdef GATE_CHECK_EN
      xor_fault = 1'b1;
      run(10, 0, 1'b0, 3'd2);
      repeat (3) tick();
      check_eq("err_cnt_held", {29'd0, err0}, 32'd2);
      xor_fault = 1'b0;
      run(10, 0, 1'b1, 3'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
